// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory definitions: memory width defaults, arbiter state
// encoding and requester index constants.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam logic [1:0] ARB  = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin select: a lone requester wins, a contested cycle goes
// to the requester named by rr.
module rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] win
);

    assign win[REQ_CPU] = req[REQ_CPU] & (~req[REQ_DMA] | ~rr);
    assign win[REQ_DMA] = req[REQ_DMA] & (~req[REQ_CPU] |  rr);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU = 0, DMA/debug = 1) with registered
// read return. Define DMEM_ARB_LOCK_EN to enable locked ownership bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              lock_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              lock_1,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] req;
    logic [1:0] win;
    logic [1:0] gnt;
    logic [1:0] state;
    logic [1:0] stateNext;
    logic       rr;
    logic       rrNext;

    assign req = {req_1, req_0};

    rr_pick uPick (
        .req (req),
        .rr  (rr),
        .win (win)
    );

    // Grants are gated by reset so nothing is accepted while rst is low.
    // NOTE: every variable in an always_comb gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        gnt = '0;
        if (rst) begin
            case (state)
                ARB:     gnt = win;
                OWN0:    gnt[REQ_CPU] = req_0;
                OWN1:    gnt[REQ_DMA] = req_1;
                default: gnt = '0;
            endcase
        end
    end

    assign gnt_0     = gnt[REQ_CPU];
    assign gnt_1     = gnt[REQ_DMA];
    assign mem_we    = (gnt_0 & we_0) | (gnt_1 & we_1);
    assign mem_addr  = gnt_1 ? addr_1  : addr_0;
    assign mem_wdata = gnt_1 ? wdata_1 : wdata_0;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LCNT_MAX = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] lcnt;
    logic [CNT_W-1:0] lcntNext;
    logic [CNT_W-1:0] lcntInc;
    logic             ownLock;

    assign lcntInc = (lcnt == LCNT_MAX) ? lcnt : lcnt + CNT_W'(1);
    assign ownLock = (state == OWN1) ? lock_1 : lock_0;

    always_comb begin
        stateNext = state;
        rrNext    = rr;
        lcntNext  = lcnt;
        case (state)
            ARB: begin
                if (|gnt) begin
                    rrNext = gnt[REQ_CPU];
                    // A one-grant limit is exhausted by the locking access itself.
                    if (((gnt_0 & lock_0) | (gnt_1 & lock_1)) && (LOCK_MAX > 1)) begin
                        stateNext = gnt_0 ? OWN0 : OWN1;
                        lcntNext  = CNT_W'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                if (!(|gnt)) begin
                    stateNext = ARB;
                end else begin
                    lcntNext = lcntInc;
                    if (lcntInc == LCNT_MAX) begin
                        stateNext = ARB;
                        rrNext    = (state == OWN0);
                    end else if (!ownLock) begin
                        stateNext = ARB;
                    end
                end
            end
            default: stateNext = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt <= '0;
        end else begin
            lcnt <= lcntNext;
        end
    end
`else
    logic unusedLock;

    assign unusedLock = lock_0 | lock_1;

    always_comb begin
        stateNext = ARB;
        rrNext    = rr;
        if (|gnt) begin
            rrNext = gnt[REQ_CPU];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            rr    <= 1'b0;
        end else begin
            state <= stateNext;
            rr    <= rrNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            rvalid_0 <= gnt_0 & ~we_0;
            rvalid_1 <= gnt_1 & ~we_1;
            if (gnt_0 && !we_0) begin
                rdata_0 <= mem_rdata;
            end
            if (gnt_1 && !we_1) begin
                rdata_1 <= mem_rdata;
            end
        end
    end

endmodule
